// File: rtl/div_restoring_seq_pkg.sv
// Shared constants for the restoring divider: FSM state encoding and default operand width.
package div_restoring_seq_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/div_restoring_seq_sub_borrow_cell.sv
// Ripple-borrow subtractor (diff = a - b) built from full-subtractor bit cells.
module div_restoring_seq_sub_borrow_cell #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic [WIDTH:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
    assign borrow[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
  end

  assign borrow_out = borrow[WIDTH];

endmodule

// File: rtl/div_restoring_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define DIV_ZERO_FAST_EN to finish a divide-by-zero in one cycle instead of WIDTH+1.
module div_restoring_seq
  import div_restoring_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  // Holds the unconsumed dividend bits in the top and the quotient bits shifted in below.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             unused_trial_msb;

  assign shifted = {rem_q, quo_q[WIDTH-1]};

  div_restoring_seq_sub_borrow_cell #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a         (shifted),
    .b         ({1'b0, divisor_q}),
    .diff      (trial),
    .borrow_out(borrow)
  );

  // Without a borrow the trial result is below the divisor, so its MSB is always zero.
  assign unused_trial_msb = trial[WIDTH];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          quo_d     = dividend;
          rem_d     = '0;
          divisor_d = divisor;
          count_d   = CntW'(WIDTH);
          dbz_d     = 1'b0;
          state_d   = CALC;
`ifdef DIV_ZERO_FAST_EN
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        quo_d   = {quo_q[WIDTH-2:0], ~borrow};
        rem_d   = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        count_d = count_q - CntW'(1);
        if (count_q == CntW'(1)) begin
          state_d = DONE;
          dbz_d   = (divisor_q == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_restoring_seq.sv
// Directed self-checking bench for div_restoring_seq at WIDTH=4.
module tb_div_restoring_seq;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned MaxWait = 20;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_checks;
  int n_fail;

  div_restoring_seq #(
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Edges after the accepting edge until done is first seen (sampled 1ns after each edge).
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < MaxWait) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_div(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                         input logic [3:0] er, input string tag);
    int lat;
    int exp_lat;
    exp_lat = WIDTH;
`ifdef DIV_ZERO_FAST_EN
    if (b == 4'd0) exp_lat = 0;
`endif
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " quotient"}, quotient, eq);
    check_eq({tag, " remainder"}, remainder, er);
    check_eq({tag, " div_by_zero"}, div_by_zero, (b == 4'd0));
    @(posedge clk);
    #1;
    check_eq({tag, " done single cycle"}, done, 0);
    check_eq({tag, " idle after done"}, busy, 0);
  endtask

  initial begin
    int lat;
    int done_idx[$];
    logic [3:0] av, bv, mq, mr;

    n_checks = 0;
    n_fail   = 0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst      = 1'b1;
    #1;
    check_eq("reset busy", busy, 0);
    check_eq("reset done", done, 0);
    check_eq("reset quotient", quotient, 0);
    check_eq("reset remainder", remainder, 0);
    check_eq("reset div_by_zero", div_by_zero, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_div(4'd13, 4'd4, 4'd3, 4'd1, "13/4");
    run_div(4'd15, 4'd1, 4'd15, 4'd0, "15/1");
    run_div(4'd3, 4'd7, 4'd0, 4'd3, "3/7");
    run_div(4'd9, 4'd0, 4'd15, 4'd9, "9/0");
    run_div(4'd0, 4'd5, 4'd0, 4'd0, "0/5");
    run_div(4'd15, 4'd15, 4'd1, 4'd0, "15/15");

    // Second start while busy must not disturb the running 6/2.
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    wait_done(lat);
    check_eq("ignored start latency", lat + 3, WIDTH);
    check_eq("ignored start quotient", quotient, 3);
    check_eq("ignored start remainder", remainder, 0);
    @(posedge clk);
    #1;
    check_eq("ignored start idle", busy, 0);

    // Start held high: accepts every WIDTH+2 cycles, results held through the following idle cycle.
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd4;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_idx.push_back(cyc);
        check_eq("b2b quotient at done", quotient, 3);
        check_eq("b2b remainder at done", remainder, 1);
      end else if (done_idx.size() > 0 && done_idx[done_idx.size()-1] == cyc - 1) begin
        check_eq("b2b quotient held", quotient, 3);
        check_eq("b2b remainder held", remainder, 1);
      end
    end
    start = 1'b0;
    check_eq("b2b done count", done_idx.size(), 3);
    if (done_idx.size() == 3) begin
      check_eq("b2b first done", done_idx[0], WIDTH);
      check_eq("b2b period 1", done_idx[1] - done_idx[0], WIDTH + 2);
      check_eq("b2b period 2", done_idx[2] - done_idx[1], WIDTH + 2);
    end
    lat = 0;
    while (busy === 1'b1 && lat < MaxWait) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("b2b drains to idle", busy, 0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("async rst busy", busy, 0);
    check_eq("async rst done", done, 0);
    check_eq("async rst quotient", quotient, 0);
    check_eq("async rst remainder", remainder, 0);
    check_eq("async rst div_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk);
      #1;
      if (done) lat++;
    end
    check_eq("no done after abort", lat, 0);
    run_div(4'd11, 4'd3, 4'd3, 4'd2, "11/3 after rst");

    // Full operand sweep against a behavioural model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        av = a[3:0];
        bv = b[3:0];
        if (bv == 4'd0) begin
          mq = 4'hf;
          mr = av;
        end else begin
          mq = av / bv;
          mr = av % bv;
        end
        run_div(av, bv, mq, mr, $sformatf("sweep %0d/%0d", a, b));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_restoring_seq.md
Name: div_restoring_seq

Overview:
Multi-cycle unsigned restoring divider. It is the inverse-direction companion to our combinational ripple adder: it performs repeated trial subtraction, one quotient bit per clock. It sits beside the adder blocks in the arithmetic library and is started by a single-cycle request pulse. It reports completion with a one-cycle done pulse and holds its results until the next accepted start.

Parameters:
WIDTH, 4, operand/quotient/remainder width in bits (legal range 2..16)

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend; captured on accepted start
divisor  input  WIDTH  unsigned divisor; captured on accepted start
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse; results valid on and after this cycle
quotient  output  WIDTH  result quotient; held until the next accepted start
remainder  output  WIDTH  result remainder; held until the next accepted start
div_by_zero  output  1  high with done when the captured divisor was 0; held with results

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- On rst: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers cleared.
- States and transitions:
  - IDLE: start=1 -> capture operands, iteration counter=WIDTH, partial remainder=0, clear div_by_zero -> CALC.
  - CALC: each cycle performs one iteration; after the WIDTH-th iteration -> DONE.
  - DONE: done=1 for exactly this cycle -> IDLE.
- Iteration, MSB first:
  - shift {partial remainder, dividend} left by 1.
  - trial = partial remainder - divisor, computed at WIDTH+1 bits.
  - no borrow: partial remainder = trial, quotient bit = 1.
  - borrow: restore the previous value, quotient bit = 0.
- Latency: start accepted at edge N -> done high in cycle N+WIDTH+1. For WIDTH=4, done is high 5 cycles after the accept edge.
- Between the accepting edge and done, quotient/remainder may show intermediate values; they are valid only from done onward.
- start while busy (CALC or DONE): ignored, with no effect on operands or timing.
- start in the same cycle as done: ignored, because the state is DONE. The next start is accepted from IDLE one cycle later.
- Divide by zero (default build):
  - runs the full WIDTH iterations.
  - result is quotient = all ones, remainder = dividend.
  - div_by_zero=1 at done.
- Widths:
  - all arithmetic is unsigned.
  - the trial subtraction is WIDTH+1 bits so the borrow is never lost.
  - remainder < divisor is always true for a nonzero divisor.
- rst mid-operation: immediate abort to the reset values listed above; no done pulse is produced.

Optional Feature:
Macro: DIV_ZERO_FAST_EN.
- Defined: a start with divisor==0 goes IDLE -> DONE directly, skipping CALC.
  - quotient = all ones, remainder = dividend, div_by_zero=1.
  - done is high in cycle N+1 after the accept edge N.
- Not defined: divide by zero takes the normal WIDTH+1 latency and gives the identical result values.
- Nonzero-divisor behaviour is identical in both builds.

Decomposition:
- Shared package/header: state encoding constants (IDLE, CALC, DONE) and the default WIDTH constant.
- One natural sub-module: sub_borrow_cell.
  - a WIDTH+1-bit ripple subtractor built from full-subtractor bit cells.
  - outputs difference and borrow-out; it is the subtraction counterpart of the adder cell.

Test Plan:
- WIDTH=4: dividend=13, divisor=4, start pulse -> busy for 5 cycles; done in cycle N+5; quotient=3, remainder=1, div_by_zero=0.
- 15/1 -> quotient=15, remainder=0. 3/7 -> quotient=0, remainder=3. Exhaustive sweep of all 256 operand pairs against a reference model; every done is a single cycle.
- 9/0 -> quotient=15, remainder=9, div_by_zero=1. done at N+5 without DIV_ZERO_FAST_EN; at N+1 with it.
- start with 6/2 immediately followed by start with 14/3 two cycles later, while busy -> second start ignored; result quotient=3, remainder=0.
- Back-to-back: start held high continuously -> accepts occur every WIDTH+2 cycles (6 for WIDTH=4); results stay stable between done pulses.
- rst asserted asynchronously mid-CALC (between clock edges) -> all outputs 0 immediately; no done; a fresh start afterwards divides correctly.
